// File: rtl/player_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | player_pkg: shared types and constants for the audio playback engine |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package player_pkg;

    localparam int ADDR_W   = 23;
    localparam int SAMPLE_W = 16;

    localparam logic [ADDR_W-1:0] HDR_HI_OFS = 23'd0;
    localparam logic [ADDR_W-1:0] HDR_LO_OFS = 23'd1;
    localparam logic [ADDR_W-1:0] DATA_OFS   = 23'd2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_HI = 3'd1,
        S_HDR_LO = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4,
        S_ABORT  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/player_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | player_fifo: synchronous show-ahead FIFO with flush                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module player_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    cnt_q;
    logic             w_push;
    logic             w_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (w_push) wr_q <= wr_q + AW'(1);
            if (w_pop)  rd_q <= rd_q + AW'(1);
            if (w_push && !w_pop)      cnt_q <= cnt_q + CW'(1);
            else if (!w_push && w_pop) cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/audio_player.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | audio_player: header-driven track streamer feeding a DAC via FIFO    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module audio_player
    import player_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                play_start,
    input  logic [ADDR_W-1:0]   play_select,
    input  logic                play_pause,
    input  logic                play_stop,
    output logic                play_done,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic                o_mem_read,
    input  logic                i_mem_waitrequest,
    input  logic [SAMPLE_W-1:0] i_mem_readdata,
    input  logic                i_mem_readdatavalid,
    input  logic                i_sample_req,
    output logic [SAMPLE_W-1:0] o_sample,
    output logic                o_underrun
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]   fetched_q, fetched_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_read_q, mem_read_d;
    logic                pend_q, pend_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                underrun_q, underrun_d;

    logic                fifo_flush, fifo_push, fifo_pop;
    logic                fifo_empty, fifo_full;
    logic [SAMPLE_W-1:0] fifo_rdata;
    logic [CW-1:0]       fifo_count;

    logic                w_accept, w_rdv, w_inflight, w_active;
    logic [CW-1:0]       w_level;
    logic [ADDR_W-1:0]   w_len;

    player_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_rst),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .wdata_i (i_mem_readdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign w_accept   = mem_read_q & ~i_mem_waitrequest;
    assign w_rdv      = i_mem_readdatavalid & pend_q;
    assign w_inflight = mem_read_q | (pend_q & ~w_rdv);
    assign w_active   = (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign w_level    = fifo_count + CW'(pend_q);

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        addr_d     = addr_q;
        len_d      = len_q;
        fetched_d  = fetched_q;
        mem_addr_d = mem_addr_q;
        mem_read_d = mem_read_q;
        pend_d     = pend_q;
        sample_d   = sample_q;
        underrun_d = underrun_q;
        fifo_flush = 1'b0;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        w_len      = {len_q[ADDR_W-1:16], i_mem_readdata};

        if (w_accept) begin
            mem_read_d = 1'b0;
            pend_d     = 1'b1;
        end
        if (w_rdv) pend_d = 1'b0;

        if (i_sample_req) begin
            if (w_active && !play_pause && !fifo_empty) begin
                fifo_pop = 1'b1;
                sample_d = fifo_rdata;
            end else begin
                sample_d = '0;
                if (w_active && !play_pause) underrun_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (play_start) begin
                    base_d     = play_select;
                    mem_addr_d = play_select + HDR_HI_OFS;
                    mem_read_d = 1'b1;
                    len_d      = '0;
                    fetched_d  = '0;
                    sample_d   = '0;
                    underrun_d = 1'b0;
                    fifo_flush = 1'b1;
                    state_d    = S_HDR_HI;
                end
            end
            S_HDR_HI: begin
                if (w_rdv) begin
                    len_d[ADDR_W-1:16] = i_mem_readdata[6:0];
                    mem_addr_d         = base_q + HDR_LO_OFS;
                    mem_read_d         = 1'b1;
                    state_d            = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (w_rdv) begin
                    len_d = w_len;
                    if (w_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        mem_addr_d = base_q + DATA_OFS;
                        addr_d     = base_q + DATA_OFS + ADDR_W'(1);
                        mem_read_d = 1'b1;
                        fetched_d  = ADDR_W'(1);
                        state_d    = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (w_rdv) begin
                    fifo_push = ~fifo_full;
                    if (fetched_q == len_q) state_d = S_DRAIN;
                end
                if (!mem_read_q && !pend_q && (fetched_q < len_q) &&
                    (w_level < CW'(FIFO_DEPTH))) begin
                    mem_addr_d = addr_q;
                    mem_read_d = 1'b1;
                    addr_d     = addr_q + ADDR_W'(1);
                    fetched_d  = fetched_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (fifo_empty) state_d = S_DONE;
            end
            S_ABORT: begin
                if (w_rdv) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Stop cancels any read not yet on the bus; one already presented must finish.
        if (play_stop && (state_q inside {S_HDR_HI, S_HDR_LO, S_STREAM, S_DRAIN})) begin
            fifo_flush = 1'b1;
            fifo_push  = 1'b0;
            mem_read_d = mem_read_q & ~w_accept;
            mem_addr_d = mem_addr_q;
            state_d    = w_inflight ? S_ABORT : S_DONE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            fetched_q  <= '0;
            mem_addr_q <= '0;
            mem_read_q <= 1'b0;
            pend_q     <= 1'b0;
            sample_q   <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            fetched_q  <= fetched_d;
            mem_addr_q <= mem_addr_d;
            mem_read_q <= mem_read_d;
            pend_q     <= pend_d;
            sample_q   <= sample_d;
            underrun_q <= underrun_d;
        end
    end

    assign play_done  = (state_q == S_DONE);
    assign o_mem_addr = mem_addr_q;
    assign o_mem_read = mem_read_q;
    assign o_sample   = sample_q;
    assign o_underrun = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_player.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_audio_player: directed scoreboard bench for audio_player          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_audio_player;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        play_start = 1'b0;
    logic [22:0] play_select = '0;
    logic        play_pause = 1'b0;
    logic        play_stop = 1'b0;
    logic        play_done;
    logic [22:0] mem_addr;
    logic        mem_read;
    logic        stall = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_valid;
    logic        sample_req = 1'b0;
    logic [15:0] sample;
    logic        underrun;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int lat = 1;
    int pend_cnt;
    logic [15:0] cap;
    logic        s_pend;

    logic [15:0] mem_model [int];
    logic [22:0] exp_addr_q [$];
    logic [15:0] exp_s_q [$];

    always #5 clk = ~clk;

    audio_player #(.FIFO_DEPTH(4)) dut (
        .i_clk               (clk),
        .i_rst               (rst_n),
        .play_start          (play_start),
        .play_select         (play_select),
        .play_pause          (play_pause),
        .play_stop           (play_stop),
        .play_done           (play_done),
        .o_mem_addr          (mem_addr),
        .o_mem_read          (mem_read),
        .i_mem_waitrequest   (stall),
        .i_mem_readdata      (rsp_data),
        .i_mem_readdatavalid (rsp_valid),
        .i_sample_req        (sample_req),
        .o_sample            (sample),
        .o_underrun          (underrun)
    );

    function automatic logic [15:0] rd_word(logic [22:0] a);
        return mem_model.exists(int'(a)) ? mem_model[int'(a)] : 16'hDEAD;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory responder: fixed latency, one outstanding read.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            pend_cnt  <= 0;
            cap       <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt <= pend_cnt - 1;
                if (pend_cnt == 1) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= cap;
                end
            end
            if (mem_read && !stall) begin
                cap      <= rd_word(mem_addr);
                pend_cnt <= lat;
            end
        end
    end

    always @(negedge clk) begin
        if (play_done) done_cnt <= done_cnt + 1;
    end

    always @(negedge clk) begin
        if (rst_n && mem_read && !stall) begin
            checks++;
            assert (exp_addr_q.size() > 0) else begin
                failures++;
                $error("FAIL rd_unexpected observed=%0h expected=none", mem_addr);
            end
            if (exp_addr_q.size() > 0) chk("rd_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            s_pend <= 1'b0;
        end else begin
            if (s_pend) begin
                checks++;
                assert (exp_s_q.size() > 0) else begin
                    failures++;
                    $error("FAIL sample_unexpected observed=%0h expected=none", sample);
                end
                if (exp_s_q.size() > 0) chk("sample", 32'(sample), 32'(exp_s_q.pop_front()));
            end
            s_pend <= sample_req;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(int n);
        repeat (n) step();
    endtask

    task automatic req(logic [15:0] exp, int gap);
        exp_s_q.push_back(exp);
        sample_req = 1'b1;
        step();
        sample_req = 1'b0;
        wait_n(gap - 1);
    endtask

    task automatic start(logic [22:0] sel);
        play_select = sel;
        play_start  = 1'b1;
        step();
        play_start  = 1'b0;
    endtask

    task automatic load_track(logic [22:0] base, int len, logic [15:0] seed);
        logic [22:0] a;
        mem_model[int'(base)] = 16'(len >> 16);
        a = base + 23'd1;
        mem_model[int'(a)] = 16'(len);
        exp_addr_q.push_back(base);
        exp_addr_q.push_back(a);
        for (int i = 0; i < len; i++) begin
            a = base + 23'(2 + i);
            mem_model[int'(a)] = seed + 16'(i) * 16'h1111;
            exp_addr_q.push_back(a);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        wait_n(3);
        chk("rst_sample", 32'(sample), 0);
        chk("rst_read", 32'(mem_read), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_done", 32'(play_done), 0);
        chk("rst_underrun", 32'(underrun), 0);
        rst_n = 1'b1;
        wait_n(2);

        // Basic playback
        load_track(23'h000100, 3, 16'h1111);
        d0 = done_cnt;
        start(23'h000100);
        wait_n(30);
        req(16'h1111, 2);
        req(16'h2222, 2);
        req(16'h3333, 2);
        wait_n(6);
        chk("basic_done", 32'(done_cnt - d0), 1);
        chk("basic_underrun", 32'(underrun), 0);
        chk("basic_reads_left", 32'(exp_addr_q.size()), 0);

        // Zero length
        load_track(23'h000200, 0, 16'h0);
        d0 = done_cnt;
        start(23'h000200);
        wait_n(15);
        chk("zero_done", 32'(done_cnt - d0), 1);
        chk("zero_sample", 32'(sample), 0);
        chk("zero_reads_left", 32'(exp_addr_q.size()), 0);
        req(16'h0000, 2);

        // Pause
        load_track(23'h000300, 8, 16'hA001);
        d0 = done_cnt;
        start(23'h000300);
        wait_n(40);
        req(16'hA001, 2);
        req(16'hB112, 2);
        play_pause = 1'b1;
        wait_n(30);
        req(16'h0000, 3);
        req(16'h0000, 3);
        chk("pause_fetch_stopped", 32'(exp_addr_q.size()), 2);
        play_pause = 1'b0;
        for (int i = 2; i < 8; i++) req(16'hA001 + 16'(i) * 16'h1111, 8);
        wait_n(6);
        chk("pause_done", 32'(done_cnt - d0), 1);
        chk("pause_underrun", 32'(underrun), 0);

        // Stop during stall
        mem_model[32'h400] = 16'h0000;
        mem_model[32'h401] = 16'h0008;
        exp_addr_q.push_back(23'h000400);
        d0 = done_cnt;
        stall = 1'b1;
        start(23'h000400);
        wait_n(2);
        play_stop = 1'b1;
        step();
        play_stop = 1'b0;
        chk("stop_hold_read", 32'(mem_read), 1);
        chk("stop_hold_addr", 32'(mem_addr), 32'h400);
        chk("stop_no_early_done", 32'(done_cnt - d0), 0);
        wait_n(2);
        chk("stop_hold_read2", 32'(mem_read), 1);
        stall = 1'b0;
        wait_n(10);
        chk("stop_done", 32'(done_cnt - d0), 1);
        chk("stop_read_idle", 32'(mem_read), 0);
        wait_n(10);
        chk("stop_done_once", 32'(done_cnt - d0), 1);
        chk("stop_reads_left", 32'(exp_addr_q.size()), 0);

        // Underrun and address wrap
        lat = 10;
        mem_model[32'h7FFFFE] = 16'h0000;
        mem_model[32'h7FFFFF] = 16'h0002;
        mem_model[32'h000000] = 16'h5555;
        mem_model[32'h000001] = 16'h6666;
        exp_addr_q.push_back(23'h7FFFFE);
        exp_addr_q.push_back(23'h7FFFFF);
        exp_addr_q.push_back(23'h000000);
        exp_addr_q.push_back(23'h000001);
        d0 = done_cnt;
        start(23'h7FFFFE);
        for (int i = 0; i < 9; i++) req(16'h0000, 4);
        chk("wrap_underrun_set", 32'(underrun), 1);
        wait_n(30);
        req(16'h5555, 4);
        req(16'h6666, 4);
        wait_n(4);
        chk("wrap_done", 32'(done_cnt - d0), 1);
        chk("wrap_underrun_sticky", 32'(underrun), 1);
        chk("wrap_reads_left", 32'(exp_addr_q.size()), 0);

        // Reset mid-stream
        lat = 1;
        load_track(23'h000100, 3, 16'h1111);
        start(23'h000100);
        wait_n(8);
        chk("mid_reading", 32'(mem_read | dut.pend_q), 1);
        wait_n(12);
        req(16'h1111, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sample", 32'(sample), 0);
        chk("mid_rst_read", 32'(mem_read), 0);
        chk("mid_rst_addr", 32'(mem_addr), 0);
        chk("mid_rst_done", 32'(play_done), 0);
        exp_addr_q.delete();
        exp_s_q.delete();
        wait_n(2);
        rst_n = 1'b1;
        wait_n(2);
        load_track(23'h000100, 3, 16'h1111);
        d0 = done_cnt;
        start(23'h000100);
        wait_n(30);
        req(16'h1111, 2);
        req(16'h2222, 2);
        req(16'h3333, 2);
        wait_n(6);
        chk("post_rst_done", 32'(done_cnt - d0), 1);
        chk("post_rst_reads_left", 32'(exp_addr_q.size()), 0);
        chk("scoreboard_empty", 32'(exp_s_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
